// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: frame size, FSM encoding, frame payload, parity helper.
package ps2_host_tx_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_BYTE_W     = 8;
  localparam int unsigned SHREG_W        = PS2_BYTE_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE
  } state_e;

  // Bits shifted out after the start bit, LSB of data first
  typedef struct packed {
    logic                  stop;
    logic                  parity;
    logic [PS2_BYTE_W-1:0] data;
  } frame_t;

  // Odd parity over one data byte (also used by the receiver check)
  function automatic logic odd_parity(input logic [PS2_BYTE_W-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command byte handshake between the SoC and the PS/2 host transmitter.
interface ps2_host_tx_if;
  import ps2_host_tx_pkg::*;

  logic                  tx_valid;
  logic [PS2_BYTE_W-1:0] tx_data;
  logic                  tx_ready;
  logic                  busy;
  logic                  tx_done;
  logic                  tx_err;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, busy, tx_done, tx_err
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, busy, tx_done, tx_err
  );
endinterface

// File: rtl/ps2_host_tx_line_filter.sv
// Pad input conditioning: 2-flop synchronizer, stability filter, falling-edge strobe.
module ps2_host_tx_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchronize the asynchronous pad level; idle bus reads high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], line_in};
  end

  // Accept a new level only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= 1'b1;
      cnt_q <= '0;
      fall  <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (sync_q[1] == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        level <= sync_q[1];
        cnt_q <= '0;
        fall  <= level;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 8 data + parity + stop, ack check.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic            clk,
  input  logic            reset,
  ps2_host_tx_if.slave    bus,
  input  logic            ps2_clk_in,
  input  logic            ps2_data_in,
  output logic            ps2_clk_oe,
  output logic            ps2_data_oe
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BIT_W = 4;

  state_e             state_q, state_d;
  frame_t             shreg_q, shreg_d;
  logic [SHREG_W-1:0] shreg_bits;
  logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [INH_W-1:0]   inh_q, inh_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d, tmr_inc;
  logic               clk_oe_d, data_oe_d, ready_d, busy_d, done_d, err_d;
  logic               clk_level, clk_fall, data_level, data_fall_unused;
  logic               frame_st, timeout;

  ps2_host_tx_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk     (clk),
    .reset   (reset),
    .line_in (ps2_clk_in),
    .level   (clk_level),
    .fall    (clk_fall)
  );

  ps2_host_tx_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk     (clk),
    .reset   (reset),
    .line_in (ps2_data_in),
    .level   (data_level),
    .fall    (data_fall_unused)
  );

  assign shreg_bits = shreg_q;

  // Next-state, counters and next values of the registered outputs
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    inh_d     = inh_q;
    tmr_d     = tmr_q;
    clk_oe_d  = 1'b0;
    data_oe_d = ps2_data_oe;
    ready_d   = bus.tx_ready;
    busy_d    = bus.busy;
    done_d    = 1'b0;
    err_d     = 1'b0;
    tmr_inc   = (tmr_q == TMR_W'(TIMEOUT_CYCLES)) ? tmr_q : tmr_q + TMR_W'(1);
    frame_st  = (state_q inside {ST_START, ST_SEND, ST_ACK, ST_WAIT_IDLE});
    // A device falling edge always beats the terminal count
    timeout   = frame_st && !clk_fall && (tmr_q >= TMR_W'(TIMEOUT_CYCLES - 1));

    case (state_q)
      ST_IDLE: begin
        data_oe_d = 1'b0;
        ready_d   = 1'b1;
        busy_d    = 1'b0;
        if (bus.tx_valid && bus.tx_ready) begin
          shreg_d.stop   = 1'b1;
          shreg_d.parity = odd_parity(bus.tx_data);
          shreg_d.data   = bus.tx_data;
          state_d        = ST_INHIBIT;
          clk_oe_d       = 1'b1;
          data_oe_d      = (INHIBIT_CYCLES == 1);
          inh_d          = INH_W'(1);
          ready_d        = 1'b0;
          busy_d         = 1'b1;
        end
      end
      ST_INHIBIT: begin
        if (inh_q < INH_W'(INHIBIT_CYCLES)) begin
          clk_oe_d  = 1'b1;
          inh_d     = inh_q + INH_W'(1);
          data_oe_d = (inh_q == INH_W'(INHIBIT_CYCLES - 1));
        end else begin
          state_d   = ST_START;
          data_oe_d = 1'b1;
          tmr_d     = '0;
          bitcnt_d  = '0;
        end
      end
      ST_START: begin
        data_oe_d = 1'b1;
        bitcnt_d  = '0;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (clk_fall) begin
          data_oe_d = ~shreg_bits[bitcnt_q];
          bitcnt_d  = bitcnt_q + BIT_W'(1);
          if (bitcnt_q == BIT_W'(PS2_FRAME_BITS - 2)) state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          done_d  = ~data_level;
          err_d   = data_level;
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_level && data_level) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_st) tmr_d = clk_fall ? '0 : tmr_inc;

    if (timeout) begin
      state_d   = ST_IDLE;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      ready_d   = 1'b1;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b1;
    end
  end

  // State, datapath and output registers; reset releases both lines at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      inh_q        <= '0;
      tmr_q        <= '0;
      ps2_clk_oe   <= 1'b0;
      ps2_data_oe  <= 1'b0;
      bus.tx_ready <= 1'b1;
      bus.busy     <= 1'b0;
      bus.tx_done  <= 1'b0;
      bus.tx_err   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      inh_q        <= inh_d;
      tmr_q        <= tmr_d;
      ps2_clk_oe   <= clk_oe_d;
      ps2_data_oe  <= data_oe_d;
      bus.tx_ready <= ready_d;
      bus.busy     <= busy_d;
      bus.tx_done  <= done_d;
      bus.tx_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with a scaled-down PS/2 keyboard model on the open-collector lines.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int unsigned INHIBIT = 5000;
  localparam int unsigned TIMEOUT = 2000;
  localparam int unsigned FLEN    = 4;
  localparam int          HALF    = 40;
  localparam int          RES_DONE = 1;
  localparam int          RES_ERR  = 16;

  logic clk = 1'b0;
  logic reset;
  logic bfm_clk_low, bfm_data_low;
  logic ps2_clk_oe, ps2_data_oe;
  wire  k_clk  = ~(ps2_clk_oe  | bfm_clk_low);
  wire  k_data = ~(ps2_data_oe | bfm_data_low);

  ps2_host_tx_if bus ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (INHIBIT),
    .TIMEOUT_CYCLES (TIMEOUT),
    .FILTER_LEN     (FLEN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .ps2_clk_in  (k_clk),
    .ps2_data_in (k_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  logic [7:0] sb_bytes[$];
  int         sb_res[$];

  // Pulse monitor
  always @(negedge clk) begin
    if (bus.tx_done) done_cnt++;
    if (bus.tx_err) err_cnt++;
    if (bus.tx_done && bus.tx_err) both_cnt++;
  end

  initial begin
    #(20 * 100000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [7:0] b, input int res);
    sb_bytes.push_back(b);
    sb_res.push_back(res);
  endtask

  // Offer a byte from IDLE and check one-cycle accept latency
  task automatic send(input logic [7:0] b, input bit keep_valid, input string tag);
    check({tag, "_ready_before"}, 32'(bus.tx_ready), 32'd1);
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    @(negedge clk);
    check({tag, "_acc_clk_oe"}, 32'(ps2_clk_oe), 32'd1);
    check({tag, "_acc_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_acc_ready"}, 32'(bus.tx_ready), 32'd0);
    if (!keep_valid) bus.tx_valid = 1'b0;
  endtask

  // Measure the inhibit period; returns at the first cycle with k_clk released
  task automatic wait_inhibit(input string tag);
    int n;
    for (int i = 0; i < 300 && !ps2_clk_oe; i++) @(negedge clk);
    check({tag, "_inhibit_seen"}, 32'(ps2_clk_oe), 32'd1);
    n = 0;
    while (ps2_clk_oe && n < int'(INHIBIT) + 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_inhibit_len"}, 32'(n), 32'(INHIBIT));
  endtask

  task automatic pulse(output logic s);
    bfm_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    bfm_clk_low = 1'b0;
    s = k_data;
  endtask

  task automatic high_phase(input bit glitch);
    if (glitch) begin
      repeat (HALF / 2) @(negedge clk);
      bfm_clk_low = 1'b1;
      repeat (3) @(negedge clk);
      bfm_clk_low = 1'b0;
      repeat (HALF / 2 - 3) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
  endtask

  // Device side of one frame, from the START cycle to the return to IDLE
  task automatic bfm_frame(input bit do_ack, input int glitch_at, input string tag);
    logic       s;
    logic [9:0] bits;
    logic [7:0] exp_b;
    int         d0, e0, exp_r;
    d0 = done_cnt;
    e0 = err_cnt;
    check({tag, "_start_oe"}, 32'(ps2_data_oe), 32'd1);
    repeat (HALF) @(negedge clk);
    check({tag, "_start_bit"}, 32'(k_data), 32'd0);
    for (int i = 0; i < 10; i++) begin
      pulse(s);
      bits[i] = s;
      if (i < 9) high_phase(i == glitch_at);
    end
    repeat (HALF / 2) @(negedge clk);
    bfm_data_low = do_ack;
    repeat (HALF - HALF / 2) @(negedge clk);
    pulse(s);
    bfm_data_low = 1'b0;
    for (int i = 0; i < 500 && !bus.tx_ready; i++) @(negedge clk);
    check({tag, "_ready_after"}, 32'(bus.tx_ready), 32'd1);
    exp_b = (sb_bytes.size() > 0) ? sb_bytes.pop_front() : 8'hxx;
    exp_r = (sb_res.size() > 0) ? sb_res.pop_front() : -1;
    check({tag, "_data"}, 32'(bits[7:0]), 32'(exp_b));
    check({tag, "_parity"}, 32'(bits[8]), 32'(~^exp_b));
    check({tag, "_stop"}, 32'(bits[9]), 32'd1);
    check({tag, "_result"}, 32'((err_cnt - e0) * RES_ERR + (done_cnt - d0) * RES_DONE), 32'(exp_r));
    check({tag, "_oe_released"}, 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
  endtask

  initial begin
    logic s;
    int   n;
    reset        = 1'b1;
    bfm_clk_low  = 1'b0;
    bfm_data_low = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (5) @(negedge clk);
    check("rst_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check("rst_pulses", 32'({bus.busy, bus.tx_done, bus.tx_err}), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_ready", 32'(bus.tx_ready), 32'd1);

    // 0xED acknowledged by the device
    sb_push(8'hED, RES_DONE);
    send(8'hED, 1'b0, "ed");
    wait_inhibit("ed");
    bfm_frame(1'b1, -1, "ed");

    // 0xF4 with ack withheld
    sb_push(8'hF4, RES_ERR);
    send(8'hF4, 1'b0, "f4");
    wait_inhibit("f4");
    bfm_frame(1'b0, -1, "f4");

    // Device never clocks: timeout counted from the START cycle
    send(8'h12, 1'b0, "to");
    wait_inhibit("to");
    n = 0;
    while (!bus.tx_err && n < int'(TIMEOUT) + 50) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles", 32'(n), 32'(TIMEOUT));
    check("to_err", 32'({bus.tx_err, bus.tx_done}), 32'b10);
    check("to_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    @(negedge clk);
    check("to_err_pulse", 32'(bus.tx_err), 32'd0);
    check("to_ready", 32'(bus.tx_ready), 32'd1);
    repeat (10) @(negedge clk);

    // Reset in the middle of the frame, after the 5th device fall
    send(8'hED, 1'b0, "rs");
    wait_inhibit("rs");
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      pulse(s);
      repeat (HALF) @(negedge clk);
    end
    bfm_clk_low = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    check("rs_b4_driven", 32'(ps2_data_oe), 32'd1);
    reset = 1'b1;
    #1;
    check("rs_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
    check("rs_ready", 32'(bus.tx_ready), 32'd1);
    check("rs_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bfm_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    sb_push(8'hED, RES_DONE);
    send(8'hED, 1'b0, "rs2");
    wait_inhibit("rs2");
    bfm_frame(1'b1, -1, "rs2");

    // tx_valid held with a new byte during a frame: only taken after IDLE
    sb_push(8'hED, RES_DONE);
    sb_push(8'hAA, RES_DONE);
    send(8'hED, 1'b1, "hold");
    bus.tx_data = 8'hAA;
    wait_inhibit("hold_ed");
    bfm_frame(1'b1, -1, "hold_ed");
    wait_inhibit("hold_aa");
    bus.tx_valid = 1'b0;
    bfm_frame(1'b1, -1, "hold_aa");
    repeat (10) @(negedge clk);

    // Short low glitch on k_clk during SEND must not count as a fall
    sb_push(8'h5C, RES_DONE);
    send(8'h5C, 1'b0, "gl");
    wait_inhibit("gl");
    bfm_frame(1'b1, 3, "gl");

    check("never_both_pulses", 32'(both_cnt), 32'd0);
    check("sb_empty", 32'(sb_bytes.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
